// File: rtl/fft_power_peak.sv
// Captures one 32-bin FFT output frame, stores per-bin power re^2+im^2, tracks the peak bin,
// replays the power spectrum over a valid/ready stream and then holds the peak until re-armed.
module fft_power_peak #(
    parameter int DATA_W      = 16,
    parameter int N_POINTS    = 32,
    parameter int ADDR_W      = 5,
    parameter int START_DELAY = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fft_done,
    input  logic signed [DATA_W-1:0] data_real_in,
    input  logic signed [DATA_W-1:0] data_imag_in,
    output logic [2*DATA_W-1:0]      pwr_data,
    output logic [ADDR_W-1:0]        pwr_idx,
    output logic                     pwr_valid,
    input  logic                     pwr_ready,
    output logic [2*DATA_W-1:0]      peak_pwr,
    output logic [ADDR_W-1:0]        peak_idx,
    output logic                     peak_valid,
    output logic                     busy
);
    localparam int PW  = 2 * DATA_W;
    localparam int CW  = ADDR_W + 1;
    localparam int WCW = (START_DELAY > 2) ? $clog2(START_DELAY) : 1;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CAPTURE, S_STREAM, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              fft_done_q;
    logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [CW-1:0]     cap_cnt_q, cap_cnt_d;
    logic              s1_vld_q, s1_vld_d;
    logic [ADDR_W-1:0] s1_idx_q, s1_idx_d;
    logic [PW-1:0]     rr_q, rr_d, ii_q, ii_d;
    logic [PW-1:0]     peak_pwr_q, peak_pwr_d;
    logic [ADDR_W-1:0] peak_idx_q, peak_idx_d;
    logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
    logic [PW-1:0]     pwr_data_q, pwr_data_d;
    logic              pwr_valid_q, pwr_valid_d;
    logic              peak_valid_q, peak_valid_d;
    logic [PW-1:0]     pwr_mem_q [N_POINTS];
    logic [PW-1:0]     pwr2;
    logic [ADDR_W-1:0] rd_next;
    logic              mem_we;

    // Squares are non-negative, so the unsigned sum of the two products cannot overflow PW bits.
    assign pwr2    = rr_q + ii_q;
    assign rd_next = rd_idx_q + ADDR_W'(1);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        cap_cnt_d  = cap_cnt_q;
        s1_vld_d   = 1'b0;
        s1_idx_d   = s1_idx_q;
        rr_d       = rr_q;
        ii_d       = ii_q;
        peak_pwr_d = peak_pwr_q;
        peak_idx_d = peak_idx_q;
        rd_idx_d   = rd_idx_q;
        pwr_data_d = pwr_data_q;
        mem_we     = 1'b0;

        // Stage 2: buffer write and peak tracking; bin 0 seeds the peak.
        if (s1_vld_q) begin
            mem_we = 1'b1;
            if (s1_idx_q == '0 || pwr2 > peak_pwr_q) begin
                peak_pwr_d = pwr2;
                peak_idx_d = s1_idx_q;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (fft_done && !fft_done_q) begin
                    wait_cnt_d = '0;
                    cap_cnt_d  = '0;
                    state_d    = (START_DELAY > 1) ? S_WAIT : S_CAPTURE;
                end
            end
            S_WAIT: begin
                if (!fft_done) state_d = S_IDLE;
                else if (int'(wait_cnt_q) >= START_DELAY - 2) state_d = S_CAPTURE;
                else wait_cnt_d = wait_cnt_q + WCW'(1);
            end
            S_CAPTURE: begin
                if (!fft_done) begin
                    state_d = S_IDLE;
                end else begin
                    cap_cnt_d = cap_cnt_q + CW'(1);
                    if (cap_cnt_q < CW'(N_POINTS)) begin
                        s1_vld_d = 1'b1;
                        s1_idx_d = cap_cnt_q[ADDR_W-1:0];
                        rr_d     = data_real_in * data_real_in;
                        ii_d     = data_imag_in * data_imag_in;
                    end
                    // Second drain cycle: last bin is in the buffer, prefetch bin 0.
                    if (cap_cnt_q == CW'(N_POINTS + 1)) begin
                        state_d    = S_STREAM;
                        rd_idx_d   = '0;
                        pwr_data_d = pwr_mem_q[0];
                    end
                end
            end
            S_STREAM: begin
                if (pwr_ready) begin
                    if (rd_idx_q == ADDR_W'(N_POINTS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        rd_idx_d   = rd_next;
                        pwr_data_d = pwr_mem_q[rd_next];
                    end
                end
            end
            S_DONE: begin
                if (!fft_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        pwr_valid_d  = (state_d == S_STREAM);
        peak_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            fft_done_q   <= 1'b0;
            wait_cnt_q   <= '0;
            cap_cnt_q    <= '0;
            s1_vld_q     <= 1'b0;
            s1_idx_q     <= '0;
            rr_q         <= '0;
            ii_q         <= '0;
            peak_pwr_q   <= '0;
            peak_idx_q   <= '0;
            rd_idx_q     <= '0;
            pwr_data_q   <= '0;
            pwr_valid_q  <= 1'b0;
            peak_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fft_done_q   <= fft_done;
            wait_cnt_q   <= wait_cnt_d;
            cap_cnt_q    <= cap_cnt_d;
            s1_vld_q     <= s1_vld_d;
            s1_idx_q     <= s1_idx_d;
            rr_q         <= rr_d;
            ii_q         <= ii_d;
            peak_pwr_q   <= peak_pwr_d;
            peak_idx_q   <= peak_idx_d;
            rd_idx_q     <= rd_idx_d;
            pwr_data_q   <= pwr_data_d;
            pwr_valid_q  <= pwr_valid_d;
            peak_valid_q <= peak_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) pwr_mem_q[s1_idx_q] <= pwr2;
    end

    assign pwr_data   = pwr_data_q;
    assign pwr_idx    = rd_idx_q;
    assign pwr_valid  = pwr_valid_q;
    assign peak_pwr   = peak_pwr_q;
    assign peak_idx   = peak_idx_q;
    assign peak_valid = peak_valid_q;
    assign busy       = (state_q == S_WAIT) || (state_q == S_CAPTURE) || (state_q == S_STREAM);
endmodule

// File: tb/tb_fft_power_peak.sv
// Randomised bench for fft_power_peak: the expected spectrum and peak come from plain arithmetic
// over the driven bins; a negedge monitor checks every stream beat and the held peak.
module tb_fft_power_peak;
    localparam int N = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic fft_done = 1'b0;
    logic signed [15:0] data_real_in = '0, data_imag_in = '0;
    logic [31:0] pwr_data, peak_pwr;
    logic [4:0]  pwr_idx, peak_idx;
    logic pwr_valid, pwr_ready, peak_valid, busy;

    fft_power_peak dut (
        .clk(clk), .reset(reset), .fft_done(fft_done),
        .data_real_in(data_real_in), .data_imag_in(data_imag_in),
        .pwr_data(pwr_data), .pwr_idx(pwr_idx), .pwr_valid(pwr_valid), .pwr_ready(pwr_ready),
        .peak_pwr(peak_pwr), .peak_idx(peak_idx), .peak_valid(peak_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    logic signed [15:0] re_v [N], im_v [N];
    longint exp_pwr [N];
    longint exp_peak_pwr;
    int     exp_peak_idx;
    int     exp_pos = 0;
    bit     expect_stream = 1'b0;
    int     rdy_mode = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: power per bin and first-occurrence maximum.
    task automatic build_model();
        for (int k = 0; k < N; k++)
            exp_pwr[k] = longint'(re_v[k]) * re_v[k] + longint'(im_v[k]) * im_v[k];
        exp_peak_idx = 0;
        for (int k = 1; k < N; k++)
            if (exp_pwr[k] > exp_pwr[exp_peak_idx]) exp_peak_idx = k;
        exp_peak_pwr = exp_pwr[exp_peak_idx];
    endtask

    // Downstream ready pattern, changed just after each rising edge.
    initial begin
        int ph = 0;
        pwr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       pwr_ready = (ph % 4 == 0) || (ph % 4 == 3);
                2:       pwr_ready = 1'($urandom_range(0, 1));
                default: pwr_ready = 1'b1;
            endcase
            ph++;
        end
    end

    // Monitor.
    initial begin
        bit stalled = 1'b0;
        logic [31:0] held_d = '0;
        logic [4:0]  held_i = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                stalled = 1'b0;
            end else begin
                if (pwr_valid && peak_valid) chk("valid_overlap", 1, 0);
                if (!expect_stream && (pwr_valid || peak_valid)) chk("unexpected_output", 1, 0);
                if (pwr_valid && expect_stream) begin
                    if (stalled) begin
                        chk("hold_data", pwr_data, held_d);
                        chk("hold_idx", pwr_idx, held_i);
                    end
                    if (exp_pos >= N) chk("extra_transfer", exp_pos, N - 1);
                    else begin
                        chk("pwr_idx", pwr_idx, exp_pos);
                        chk("pwr_data", pwr_data, exp_pwr[exp_pos]);
                    end
                    stalled = !pwr_ready;
                    held_d = pwr_data;
                    held_i = pwr_idx;
                    if (pwr_ready) exp_pos++;
                end else begin
                    stalled = 1'b0;
                end
                if (peak_valid && expect_stream) begin
                    chk("peak_pwr", peak_pwr, exp_peak_pwr);
                    chk("peak_idx", peak_idx, exp_peak_idx);
                    chk("xfer_count", exp_pos, N);
                    chk("busy_done", busy, 0);
                end
            end
        end
    end

    // One full frame; drop_early releases fft_done while the stream is running.
    task automatic run_frame(input int mode, input bit drop_early);
        bit seen = 1'b0;
        build_model();
        exp_pos = 0;
        rdy_mode = mode;
        expect_stream = 1'b1;
        fft_done = 1'b1;
        tick();
        for (int k = 0; k < N; k++) begin
            data_real_in = re_v[k];
            data_imag_in = im_v[k];
            tick();
        end
        data_real_in = 16'($urandom);
        data_imag_in = 16'($urandom);
        if (drop_early) begin
            repeat (4) tick();
            fft_done = 1'b0;
        end
        for (int c = 0; c < 600 && !seen; c++) begin
            @(negedge clk);
            if (peak_valid) seen = 1'b1;
        end
        chk("peak_reached", seen, 1);
        @(posedge clk);
        #1;
        fft_done = 1'b0;
        tick();
        tick();
        chk("peak_cleared", peak_valid, 0);
        chk("idle_busy", busy, 0);
        expect_stream = 1'b0;
        rdy_mode = 0;
        repeat (3) tick();
    endtask

    task automatic zero_bins();
        for (int k = 0; k < N; k++) begin
            re_v[k] = '0;
            im_v[k] = '0;
        end
    endtask

    task automatic rand_bins();
        for (int k = 0; k < N; k++) begin
            re_v[k] = 16'($urandom);
            im_v[k] = 16'($urandom);
        end
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_pwr_valid", pwr_valid, 0);
        chk("rst_peak_valid", peak_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pwr_data", pwr_data, 0);
        chk("rst_pwr_idx", pwr_idx, 0);
        chk("rst_peak_pwr", peak_pwr, 0);
        chk("rst_peak_idx", peak_idx, 0);
        reset = 1'b1;
        repeat (2) tick();

        // Ramp: bin k = (k,-k), power 2k^2.
        for (int k = 0; k < N; k++) begin
            re_v[k] = 16'(k);
            im_v[k] = 16'(-k);
        end
        run_frame(0, 1'b0);
        chk("model_ramp_peak", exp_peak_pwr, 1922);
        chk("model_ramp_pwr5", exp_pwr[5], 50);
        chk("dut_ramp_peak_pwr", peak_pwr, 1922);
        chk("dut_ramp_peak_idx", peak_idx, 31);

        // Full-scale negative bin: power exactly 2^31.
        zero_bins();
        re_v[7] = 16'sh8000;
        im_v[7] = 16'sh8000;
        run_frame(0, 1'b0);
        chk("model_ovf_pwr7", exp_pwr[7], 64'h8000_0000);
        chk("dut_ovf_peak_pwr", peak_pwr, 32'h8000_0000);
        chk("dut_ovf_peak_idx", peak_idx, 7);

        // Tie keeps the lowest index; stalling ready pattern.
        zero_bins();
        re_v[3] = 16'sd100;
        re_v[20] = 16'sd100;
        run_frame(1, 1'b0);
        chk("model_tie_idx", exp_peak_idx, 3);
        chk("dut_tie_peak_pwr", peak_pwr, 10000);
        chk("dut_tie_peak_idx", peak_idx, 3);

        // Asynchronous reset mid-capture, after bin 10 is sampled.
        for (int k = 0; k < N; k++) begin
            re_v[k] = 16'(k + 50);
            im_v[k] = 16'(3 * k + 1);
        end
        expect_stream = 1'b0;
        fft_done = 1'b1;
        tick();
        for (int k = 0; k <= 10; k++) begin
            data_real_in = re_v[k];
            data_imag_in = im_v[k];
            tick();
        end
        chk("pre_rst_busy", busy, 1);
        #2;
        reset = 1'b0;
        fft_done = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_peak_pwr", peak_pwr, 0);
        chk("arst_pwr_valid", pwr_valid, 0);
        chk("arst_peak_valid", peak_valid, 0);
        tick();
        reset = 1'b1;
        repeat (60) tick();
        rand_bins();
        run_frame(2, 1'b0);

        // Abort: fft_done dropped after bin 12, then a fresh frame.
        rand_bins();
        expect_stream = 1'b0;
        fft_done = 1'b1;
        tick();
        for (int k = 0; k <= 12; k++) begin
            data_real_in = re_v[k];
            data_imag_in = im_v[k];
            tick();
        end
        fft_done = 1'b0;
        tick();
        tick();
        chk("abort_busy", busy, 0);
        repeat (60) tick();
        rand_bins();
        run_frame(0, 1'b0);

        // Randomised frames, including fft_done released during the stream.
        for (int f = 0; f < 5; f++) begin
            rand_bins();
            run_frame(2, f[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fft_power_peak.md
Name: fft_power_peak

Overview:
- Downstream consumer of the 32-point FFT core.
- Watches the core's done flag and captures the 32 serially presented output bins (real/imag, bin order 0..31).
- Computes power re^2+im^2 per bin into a local buffer and tracks the peak bin.
- Replays the power spectrum over a valid/ready stream, then holds the peak result until the FFT core is re-armed.

Parameters:
- DATA_W, 16, signed width of the real/imag input samples.
- N_POINTS, 32, bins per frame.
- ADDR_W, 5, bin index width; log2(N_POINTS).
- START_DELAY, 1, cycles from the first cycle fft_done is seen high to the cycle bin 0 is on the data inputs. Matches the core's registered RAM read.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- fft_done  input  1  FFT core done flag; level, stays high while the core is in its output phase.
- data_real_in  input  DATA_W  signed real part of the current bin.
- data_imag_in  input  DATA_W  signed imaginary part of the current bin (sign already corrected by the core).
- pwr_data  output  2*DATA_W  unsigned bin power.
- pwr_idx  output  ADDR_W  bin index of pwr_data.
- pwr_valid  output  1  pwr_data/pwr_idx valid.
- pwr_ready  input  1  downstream accepts when high with pwr_valid.
- peak_pwr  output  2*DATA_W  largest bin power of the frame.
- peak_idx  output  ADDR_W  bin index of peak_pwr.
- peak_valid  output  1  peak result valid.
- busy  output  1  high in WAIT, CAPTURE and STREAM.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE.
  - All outputs 0; counters 0; buffer contents don't-care.
- States:
  - IDLE -> WAIT on the rising edge of fft_done. A registered fft_done_q is used; the edge is fft_done & ~fft_done_q.
  - WAIT counts START_DELAY-1 cycles. With START_DELAY=1 it lasts 0 extra cycles: the cycle after the edge cycle is bin 0.
  - WAIT -> CAPTURE.
- CAPTURE:
  - Samples one bin per cycle for exactly N_POINTS cycles; cap_cnt runs 0..N_POINTS-1.
  - Stage 1 registers re*re and im*im as signed products.
  - Stage 2 writes their unsigned sum (2*DATA_W bits, no overflow; max 2^31 for DATA_W=16) to buf[idx].
  - Peak compare runs in stage 2: update when power > peak_pwr (strict), so ties keep the lowest index.
  - Peak is initialised from bin 0 (power and index 0).
  - CAPTURE -> STREAM once the last bin has cleared stage 2 (2-cycle drain).
- STREAM:
  - pwr_valid=1 with buf[rd_idx], pwr_idx=rd_idx, starting at 0.
  - On pwr_valid&pwr_ready, rd_idx increments.
  - pwr_data/pwr_idx are held stable while pwr_valid=1 and pwr_ready=0.
  - After the transfer of index N_POINTS-1: pwr_valid=0 on the next cycle, go to DONE.
  - Buffer read is registered, so output data is prefetched. Back-to-back transfers at 1 per cycle are required when pwr_ready is held high.
- DONE:
  - peak_valid=1; peak_pwr/peak_idx are held.
  - DONE -> IDLE when fft_done=0, which clears peak_valid.
- fft_done falling in WAIT or CAPTURE:
  - Abort to IDLE, discarding the frame.
  - peak_valid stays 0; no stream is produced.
- fft_done falling in STREAM: ignored; the stream completes. DONE then exits immediately on the next cycle.
- fft_done rising while not IDLE: ignored.
- peak_valid and pwr_valid are never high simultaneously.
- busy=0 in IDLE and DONE.

Test Plan:
- Reset mid-CAPTURE (reset=0 for 1 cycle after bin 10) -> all outputs 0 at once (asynchronous); no stream follows; the next fft_done edge captures normally.
- Frame with bin k = (k, -k), pwr_ready=1 -> pwr_data = 2k^2 for k=0..31 on 32 consecutive cycles with pwr_idx=k; peak_idx=31, peak_pwr=1922, peak_valid=1.
- Bins all zero except bin 7=(-32768,-32768) -> pwr_data[7]=0x80000000, peak_idx=7, peak_pwr=0x80000000 (no overflow).
- Tie: bins 3 and 20 both (100,0), others 0 -> peak_idx=3, peak_pwr=10000.
- pwr_ready toggled 1,0,0,1 repeatedly -> no index skipped or duplicated; data held while stalled; 32 transfers total, then peak_valid=1.
- fft_done dropped after bin 12 is captured -> return to IDLE, pwr_valid and peak_valid never assert; a re-raised fft_done starts a fresh frame from bin 0.
